div_sequencer: RTL and testbench

//   Upstream control stage for the combinational Divider.
//   - Accepts one divide request at a time on a valid/ready interface and registers the operands.
//   - Drives those operands into the Divider and waits SETTLE cycles for its outputs to settle.
//   - Captures quotient/remainder and presents them on a valid/ready response port.
//   - Handles divide-by-zero locally, without waiting, and counts completed operations.

---
 rtl/div_sequencer.sv | 166 ++++++++++++++++
 tb/tb_div_sequencer.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_sequencer.sv
// div_sequencer: control stage wrapped around a combinational Divider.
// Accepts one request at a time and drives the registered operands into the Divider.
// It waits SETTLE cycles, then captures quotient/remainder and holds them on a
// valid/ready response port until they are accepted.
// A divide-by-zero request is answered directly, without consulting the Divider.
module div_sequencer #(
  parameter int WIDTH  = 16,
  parameter int SETTLE = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_dividend,
  input  logic [WIDTH-1:0] req_divisor,
  output logic [WIDTH-1:0] div_dividend,
  output logic [WIDTH-1:0] div_divisor,
  input  logic [WIDTH-1:0] div_quotient,
  input  logic [WIDTH-1:0] div_remainder,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_quotient,
  output logic [WIDTH-1:0] rsp_remainder,
  output logic             rsp_div0,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  // Settle counter width: wide enough to hold SETTLE itself, at least one bit.
  localparam int SW = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_RESP   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [SW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             div0_q, div0_d;
  logic [CNT_W-1:0] ops_q, ops_d;

  logic req_fire;
  logic rsp_fire;
  logic divisor_zero;
  logic settle_done;

  assign req_fire     = req_valid && (state_q == S_IDLE);
  assign rsp_fire     = rsp_ready && (state_q == S_RESP);
  assign divisor_zero = (req_divisor == '0);
  assign settle_done  = (cnt_q == SW'(1));

  // State register; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_fire) begin
          state_d = divisor_zero ? S_RESP : S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (settle_done) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_fire) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State-decoded handshake and status outputs.
  always_comb begin
    req_ready = (state_q == S_IDLE);
    rsp_valid = (state_q == S_RESP);
    busy      = (state_q != S_IDLE);
  end

  // Datapath next-state: operands move only on acceptance, results only on capture.
  always_comb begin
    cnt_d  = cnt_q;
    opa_d  = opa_q;
    opb_d  = opb_q;
    quo_d  = quo_q;
    rem_d  = rem_q;
    div0_d = div0_q;
    ops_d  = ops_q;
    case (state_q)
      S_IDLE: begin
        if (req_fire) begin
          opa_d = req_dividend;
          opb_d = req_divisor;
          if (divisor_zero) begin
            // Divider output is meaningless here, so answer directly.
            quo_d  = '1;
            rem_d  = req_dividend;
            div0_d = 1'b1;
          end else begin
            cnt_d  = SW'(SETTLE);
            div0_d = 1'b0;
          end
        end
      end
      S_SETTLE: begin
        if (settle_done) begin
          quo_d = div_quotient;
          rem_d = div_remainder;
        end
        cnt_d = cnt_q - SW'(1);
      end
      S_RESP: begin
        if (rsp_fire) begin
          ops_d = ops_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; all cleared by reset so outputs read zero immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      opa_q  <= '0;
      opb_q  <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      div0_q <= 1'b0;
      ops_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      opa_q  <= opa_d;
      opb_q  <= opb_d;
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      div0_q <= div0_d;
      ops_q  <= ops_d;
    end
  end

  assign div_dividend  = opa_q;
  assign div_divisor   = opb_q;
  assign rsp_quotient  = quo_q;
  assign rsp_remainder = rem_q;
  assign rsp_div0      = div0_q;
  assign op_count      = ops_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer with a behavioural combinational Divider.
// The counter is instantiated 8 bits wide so the wrap scenario fits a short run.
module tb_div_sequencer;

  localparam int WIDTH  = 16;
  localparam int SETTLE = 2;
  localparam int CNT_W  = 8;

  logic             clk;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_dividend;
  logic [WIDTH-1:0] req_divisor;
  logic [WIDTH-1:0] div_dividend;
  logic [WIDTH-1:0] div_divisor;
  logic [WIDTH-1:0] div_quotient;
  logic [WIDTH-1:0] div_remainder;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_quotient;
  logic [WIDTH-1:0] rsp_remainder;
  logic             rsp_div0;
  logic             busy;
  logic [CNT_W-1:0] op_count;

  int checks = 0;
  int errors = 0;

  div_sequencer #(.WIDTH(WIDTH), .SETTLE(SETTLE), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_dividend  (req_dividend),
    .req_divisor   (req_divisor),
    .div_dividend  (div_dividend),
    .div_divisor   (div_divisor),
    .div_quotient  (div_quotient),
    .div_remainder (div_remainder),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_quotient  (rsp_quotient),
    .rsp_remainder (rsp_remainder),
    .rsp_div0      (rsp_div0),
    .busy          (busy),
    .op_count      (op_count)
  );

  // Behavioural Divider; distinctive garbage on divide-by-zero.
  assign div_quotient  = (div_divisor == '0) ? 16'hBEEF : div_dividend / div_divisor;
  assign div_remainder = (div_divisor == '0) ? 16'hCAFE : div_dividend % div_divisor;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request for one cycle; returns in cycle C+1.
  task automatic start_req(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    req_valid    = 1'b1;
    req_dividend = a;
    req_divisor  = b;
    tick();
    req_valid    = 1'b0;
  endtask

  // Called in cycle C+1; returns latency L where rsp_valid first rose in C+L (31 = timeout).
  task automatic wait_rsp(output int n);
    n = 1;
    while (!rsp_valid && n < 31) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    req_dividend = '0; req_divisor = '0;
    tick(); tick();
    checks++;
    if ({req_ready, busy, rsp_valid} !== 3'b100) begin
      errors++; $display("FAIL reset_ctrl: ready/busy/valid=%b required 100", {req_ready, busy, rsp_valid});
    end
    checks++;
    if ({div_dividend, div_divisor, rsp_quotient, rsp_remainder, rsp_div0, op_count} !== '0) begin
      errors++; $display("FAIL reset_data: dd=%h dv=%h q=%h r=%h z=%b cnt=%h required all 0",
                         div_dividend, div_divisor, rsp_quotient, rsp_remainder, rsp_div0, op_count);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_normal();
    int n;
    rsp_ready = 1'b1;
    start_req(16'd100, 16'd7);
    checks++;
    if ({busy, req_ready, div_dividend, div_divisor} !== {1'b1, 1'b0, 16'd100, 16'd7}) begin
      errors++; $display("FAIL normal_accept: busy=%b ready=%b dd=%0d dv=%0d required 1 0 100 7",
                         busy, req_ready, div_dividend, div_divisor);
    end
    wait_rsp(n);
    checks++;
    if (n !== 3) begin
      errors++; $display("FAIL normal_latency: %0d required 3", n);
    end
    checks++;
    if ({rsp_quotient, rsp_remainder, rsp_div0} !== {16'd14, 16'd2, 1'b0}) begin
      errors++; $display("FAIL normal_result: q=%0d r=%0d z=%b required 14 2 0", rsp_quotient, rsp_remainder, rsp_div0);
    end
    tick();
    checks++;
    if ({op_count, rsp_valid, req_ready} !== {8'd1, 1'b0, 1'b1}) begin
      errors++; $display("FAIL normal_done: cnt=%0d valid=%b ready=%b required 1 0 1", op_count, rsp_valid, req_ready);
    end
  endtask

  task automatic test_div0();
    rsp_ready = 1'b1;
    start_req(16'd5, 16'd0);
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++; $display("FAIL div0_latency: valid=%b at C+1 required 1", rsp_valid);
    end
    checks++;
    if ({rsp_quotient, rsp_remainder, rsp_div0, div_divisor} !== {16'hFFFF, 16'd5, 1'b1, 16'd0}) begin
      errors++; $display("FAIL div0_result: q=%h r=%h z=%b dv=%h required ffff 0005 1 0000",
                         rsp_quotient, rsp_remainder, rsp_div0, div_divisor);
    end
    tick();
    checks++;
    if ({op_count, req_ready} !== {8'd2, 1'b1}) begin
      errors++; $display("FAIL div0_done: cnt=%0d ready=%b required 2 1", op_count, req_ready);
    end
  endtask

  task automatic test_backpressure();
    int n;
    rsp_ready = 1'b0;
    start_req(16'hFFFF, 16'd1);
    wait_rsp(n);
    checks++;
    if (n !== 3) begin
      errors++; $display("FAIL bp_latency: %0d required 3", n);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({rsp_valid, req_ready, op_count, rsp_quotient, rsp_remainder, rsp_div0}
          !== {1'b1, 1'b0, 8'd2, 16'hFFFF, 16'd0, 1'b0}) begin
        errors++; $display("FAIL bp_hold[%0d]: valid=%b ready=%b cnt=%0d q=%h r=%h z=%b required 1 0 2 ffff 0000 0",
                           i, rsp_valid, req_ready, op_count, rsp_quotient, rsp_remainder, rsp_div0);
      end
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    checks++;
    if ({op_count, rsp_valid, req_ready, busy} !== {8'd3, 1'b0, 1'b1, 1'b0}) begin
      errors++; $display("FAIL bp_release: cnt=%0d valid=%b ready=%b busy=%b required 3 0 1 0",
                         op_count, rsp_valid, req_ready, busy);
    end
  endtask

  task automatic test_ignore_busy_req();
    int n;
    rsp_ready    = 1'b1;
    req_valid    = 1'b1;
    req_dividend = 16'd9;
    req_divisor  = 16'd2;
    tick();
    req_dividend = 16'd30;
    req_divisor  = 16'd4;
    n = 1;
    while (!rsp_valid && n < 31) begin
      checks++;
      if ({div_dividend, div_divisor, req_ready} !== {16'd9, 16'd2, 1'b0}) begin
        errors++; $display("FAIL busy_ignore: dd=%0d dv=%0d ready=%b required 9 2 0", div_dividend, div_divisor, req_ready);
      end
      tick();
      n++;
    end
    checks++;
    if ({n, rsp_quotient, rsp_remainder} !== {32'd3, 16'd4, 16'd1}) begin
      errors++; $display("FAIL busy_first: lat=%0d q=%0d r=%0d required 3 4 1", n, rsp_quotient, rsp_remainder);
    end
    tick();
    checks++;
    if ({req_ready, div_dividend} !== {1'b1, 16'd9}) begin
      errors++; $display("FAIL busy_idle: ready=%b dd=%0d required 1 9", req_ready, div_dividend);
    end
    tick();
    req_valid = 1'b0;
    checks++;
    if ({div_dividend, div_divisor} !== {16'd30, 16'd4}) begin
      errors++; $display("FAIL busy_accept: dd=%0d dv=%0d required 30 4", div_dividend, div_divisor);
    end
    wait_rsp(n);
    checks++;
    if ({n, rsp_quotient, rsp_remainder} !== {32'd3, 16'd7, 16'd2}) begin
      errors++; $display("FAIL busy_second: lat=%0d q=%0d r=%0d required 3 7 2", n, rsp_quotient, rsp_remainder);
    end
    tick();
    checks++;
    if (op_count !== 8'd5) begin
      errors++; $display("FAIL busy_count: %0d required 5", op_count);
    end
  endtask

  task automatic test_reset_midop();
    int n;
    rsp_ready = 1'b1;
    start_req(16'd50, 16'd5);
    rst = 1'b0;
    #1;
    checks++;
    if ({busy, req_ready, rsp_valid} !== 3'b010) begin
      errors++; $display("FAIL midrst_ctrl: busy/ready/valid=%b required 010", {busy, req_ready, rsp_valid});
    end
    checks++;
    if ({div_dividend, div_divisor, rsp_quotient, rsp_remainder, rsp_div0, op_count} !== '0) begin
      errors++; $display("FAIL midrst_data: dd=%h dv=%h q=%h r=%h z=%b cnt=%h required all 0",
                         div_dividend, div_divisor, rsp_quotient, rsp_remainder, rsp_div0, op_count);
    end
    tick();
    rst = 1'b1;
    tick(); tick(); tick();
    checks++;
    if ({rsp_valid, busy} !== 2'b00) begin
      errors++; $display("FAIL midrst_norsp: valid=%b busy=%b required 0 0", rsp_valid, busy);
    end
    start_req(16'd9, 16'd3);
    wait_rsp(n);
    checks++;
    if ({n, rsp_quotient, rsp_remainder} !== {32'd3, 16'd3, 16'd0}) begin
      errors++; $display("FAIL midrst_op: lat=%0d q=%0d r=%0d required 3 3 0", n, rsp_quotient, rsp_remainder);
    end
    tick();
    checks++;
    if (op_count !== 8'd1) begin
      errors++; $display("FAIL midrst_count: %0d required 1", op_count);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    logic [WIDTH-1:0] a;
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    // op_count starts at 1 here; run 254 ops to reach 255, then one more.
    for (int i = 0; i < 255; i++) begin
      a = WIDTH'(i * 37 + 11);
      req_dividend = a;
      req_divisor  = 16'd3;
      tick();
      if (i == 254) req_valid = 1'b0;
      wait_rsp(n);
      if (i % 32 == 0 || n !== 3) begin
        checks++;
        if ({n, rsp_quotient, rsp_remainder} !== {32'd3, a / 16'd3, a % 16'd3}) begin
          errors++; $display("FAIL b2b_op[%0d]: lat=%0d q=%0d r=%0d required 3 %0d %0d",
                             i, n, rsp_quotient, rsp_remainder, a / 16'd3, a % 16'd3);
        end
      end
      if (i == 254) begin
        checks++;
        if (op_count !== 8'hFF) begin
          errors++; $display("FAIL b2b_prewrap: %h required ff", op_count);
        end
      end
      tick();
    end
    checks++;
    if ({op_count, req_ready} !== {8'h00, 1'b1}) begin
      errors++; $display("FAIL b2b_wrap: cnt=%h ready=%b required 00 1", op_count, req_ready);
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_div0();
    test_backpressure();
    test_ignore_busy_req();
    test_reset_midop();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
